// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state type, default divider and mode-0 idle levels
// for the CH376S byte master and any later SPI peripherals.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCK_LOW  = 2'd1,
    ST_SCK_HIGH = 2'd2
  } spi_state_t;

  localparam int SPI_CLK_DIV_DEFAULT = 2;

  // Mode 0: clock rests low, MOSI rests high between bytes.
  localparam logic SPI_SCK_IDLE  = 1'b0;
  localparam logic SPI_MOSI_IDLE = 1'b1;

endpackage

// File: rtl/spi_byte_master.sv
// Mode-0 single-byte SPI master: shifts din out MSB first on sdo while capturing
// sdi on each SCK rise; sdcs is the upstream ready flag (1 = idle).
module spi_byte_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       wr,
  output logic [7:0] dout,
  output logic       sdcs,
  output logic       sck,
  output logic       sdo,
  input  logic       sdi
);

  localparam int               DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  spi_state_t       state;
  logic [7:0]       tx_sr;
  logic [7:0]       rx_sr;
  logic [2:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             div_done;

  // With CLK_DIV=1 the counter is stuck at zero and every half-phase is one cycle.
  assign div_done = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      dout    <= 8'h00;
      sdcs    <= 1'b1;
      sck     <= SPI_SCK_IDLE;
      sdo     <= SPI_MOSI_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr) begin
            tx_sr   <= din;
            sdo     <= din[7];
            sdcs    <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
            state   <= ST_SCK_LOW;
          end
        end
        ST_SCK_LOW: begin
          if (div_done) begin
            sck     <= 1'b1;
            rx_sr   <= {rx_sr[6:0], sdi};
            div_cnt <= '0;
            state   <= ST_SCK_HIGH;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        ST_SCK_HIGH: begin
          if (div_done) begin
            sck     <= SPI_SCK_IDLE;
            div_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              // rx_sr already holds all eight samples taken on the rising edges.
              sdo   <= SPI_MOSI_IDLE;
              dout  <= rx_sr;
              sdcs  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              tx_sr   <= {tx_sr[6:0], 1'b0};
              sdo     <= tx_sr[6];
              bit_cnt <= bit_cnt + 3'd1;
              state   <= ST_SCK_LOW;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
